// File: rtl/proto245_cmd_pkg.sv
// Shared definitions for the proto245 command parser: command words,
// parser FSM states and byte-counter width.
package proto245_cmd_pkg;

    localparam int unsigned CMD_W      = 32;
    localparam int unsigned BYTE_CNT_W = 2;

    localparam logic [CMD_W-1:0] CMD_TEST     = 32'hBADC_0FFE;
    localparam logic [CMD_W-1:0] CMD_LED0_ON  = 32'h0017_11ED;
    localparam logic [CMD_W-1:0] CMD_LED0_OFF = 32'h00FF_11ED;

    // IDLE: nothing held; COLLECT: partial word held; DECODE: word just completed
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DECODE  = 2'd2
    } state_t;

endpackage

// File: rtl/cmd_parser.sv
// Assembles 4-byte command words (LSB first) from the proto245 RX FIFO and
// decodes them into test-start / LED0 / error actions.
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   rxfifo_rd           registered read request to the RX FIFO
//   rxfifo_data/valid   RX byte and its qualifier
//   rxfifo_empty        RX FIFO empty flag
//   test_busy           TX test generator active
//   test_start          1-cycle pulse: start TX test
//   led0                LED0 state
//   cmd_err             1-cycle pulse: unknown or rejected command
//   frame_timeout       1-cycle pulse: partial word discarded after idle
//   cmd_cnt             accepted commands, wraps
//   err_cnt             errors + timeouts, saturates at 255
module cmd_parser
    import proto245_cmd_pkg::*;
#(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              rxfifo_rd,
    input  logic [DATA_W-1:0] rxfifo_data,
    input  logic              rxfifo_valid,
    input  logic              rxfifo_empty,
    input  logic              test_busy,
    output logic              test_start,
    output logic              led0,
    output logic              cmd_err,
    output logic              frame_timeout,
    output logic [15:0]       cmd_cnt,
    output logic [7:0]        err_cnt
);

    localparam int unsigned WORD_W = 4 * DATA_W;
    localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0]      TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BYTE_CNT_W-1:0] CNT_LAST = BYTE_CNT_W'(3);

    state_t                  state_q, state_d;
    logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [WORD_W-1:0]       shreg_q, shreg_d;
    logic [DATA_W-1:0]       skid_data_q, skid_data_d;
    logic                    skid_vld_q, skid_vld_d;
    logic [TMR_W-1:0]        timer_q, timer_d;

    logic                    rxfifo_rd_d;
    logic                    test_start_d;
    logic                    led0_d;
    logic                    cmd_err_d;
    logic                    frame_timeout_d;
    logic [15:0]             cmd_cnt_d;
    logic [7:0]              err_cnt_d;

    // Word as it will look once the current byte is shifted in (MSB side)
    logic [WORD_W-1:0]       word_c;
    assign word_c = {rxfifo_data, shreg_q[WORD_W-1:DATA_W]};

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            byte_cnt_q    <= '0;
            shreg_q       <= '0;
            skid_data_q   <= '0;
            skid_vld_q    <= 1'b0;
            timer_q       <= '0;
            rxfifo_rd     <= 1'b0;
            test_start    <= 1'b0;
            led0          <= 1'b0;
            cmd_err       <= 1'b0;
            frame_timeout <= 1'b0;
            cmd_cnt       <= '0;
            err_cnt       <= '0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            shreg_q       <= shreg_d;
            skid_data_q   <= skid_data_d;
            skid_vld_q    <= skid_vld_d;
            timer_q       <= timer_d;
            rxfifo_rd     <= rxfifo_rd_d;
            test_start    <= test_start_d;
            led0          <= led0_d;
            cmd_err       <= cmd_err_d;
            frame_timeout <= frame_timeout_d;
            cmd_cnt       <= cmd_cnt_d;
            err_cnt       <= err_cnt_d;
        end
    end

    // Next-state, assembly, decode and counters
    always_comb begin
        state_d         = state_q;
        byte_cnt_d      = byte_cnt_q;
        shreg_d         = shreg_q;
        skid_data_d     = skid_data_q;
        skid_vld_d      = skid_vld_q;
        timer_d         = timer_q;
        rxfifo_rd_d     = (state_q != ST_DECODE) && !rxfifo_empty;
        test_start_d    = 1'b0;
        led0_d          = led0;
        cmd_err_d       = 1'b0;
        frame_timeout_d = 1'b0;
        cmd_cnt_d       = cmd_cnt;
        err_cnt_d       = err_cnt;

        unique case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (rxfifo_valid) begin
                    shreg_d    = word_c;
                    byte_cnt_d = BYTE_CNT_W'(1);
                    state_d    = ST_COLLECT;
                end
            end

            ST_COLLECT: begin
                if (skid_vld_q) begin
                    // Only reached right after DECODE, so byte_cnt is 0 here
                    timer_d    = '0;
                    skid_vld_d = 1'b0;
                    if (rxfifo_valid) begin
                        shreg_d    = {rxfifo_data, skid_data_q, shreg_q[WORD_W-1:2*DATA_W]};
                        byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(2);
                    end else begin
                        shreg_d    = {skid_data_q, shreg_q[WORD_W-1:DATA_W]};
                        byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                    end
                end else if (rxfifo_valid) begin
                    // A byte in the expiry cycle takes priority over the timeout
                    timer_d = '0;
                    shreg_d = word_c;
                    if (byte_cnt_q == CNT_LAST) begin
                        byte_cnt_d = '0;
                        state_d    = ST_DECODE;
                        if (word_c == WORD_W'(CMD_TEST)) begin
                            if (test_busy) begin
                                cmd_err_d = 1'b1;
                            end else begin
                                test_start_d = 1'b1;
                                cmd_cnt_d    = cmd_cnt + 16'd1;
                            end
                        end else if (word_c == WORD_W'(CMD_LED0_ON)) begin
                            led0_d    = 1'b1;
                            cmd_cnt_d = cmd_cnt + 16'd1;
                        end else if (word_c == WORD_W'(CMD_LED0_OFF)) begin
                            led0_d    = 1'b0;
                            cmd_cnt_d = cmd_cnt + 16'd1;
                        end else begin
                            cmd_err_d = 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                    end
                end else if (timer_q == TMR_LAST) begin
                    frame_timeout_d = 1'b1;
                    timer_d         = '0;
                    byte_cnt_d      = '0;
                    shreg_d         = '0;
                    state_d         = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            ST_DECODE: begin
                timer_d = '0;
                if (rxfifo_valid) begin
                    skid_data_d = rxfifo_data;
                    skid_vld_d  = 1'b1;
                    state_d     = ST_COLLECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((cmd_err_d || frame_timeout_d) && (err_cnt != 8'hFF)) begin
            err_cnt_d = err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_cmd_parser.sv
// Scoreboard bench for cmd_parser: the driver predicts each output event
// (pulse / counter change) with a small model and its cycle; the monitor
// pops and compares whenever the DUT shows an event.
module tb_cmd_parser;

    localparam int unsigned TO = 1024;

    logic        clk;
    logic        rst_n;
    logic        rxfifo_rd;
    logic [7:0]  rxfifo_data;
    logic        rxfifo_valid;
    logic        rxfifo_empty;
    logic        test_busy;
    logic        test_start;
    logic        led0;
    logic        cmd_err;
    logic        frame_timeout;
    logic [15:0] cmd_cnt;
    logic [7:0]  err_cnt;

    cmd_parser #(
        .DATA_W        (8),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rxfifo_rd    (rxfifo_rd),
        .rxfifo_data  (rxfifo_data),
        .rxfifo_valid (rxfifo_valid),
        .rxfifo_empty (rxfifo_empty),
        .test_busy    (test_busy),
        .test_start   (test_start),
        .led0         (led0),
        .cmd_err      (cmd_err),
        .frame_timeout(frame_timeout),
        .cmd_cnt      (cmd_cnt),
        .err_cnt      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event snapshot: {test_start, cmd_err, frame_timeout, led0, cmd_cnt, err_cnt}
    typedef struct {
        int          at_cyc;
        logic [27:0] snap;
    } exp_t;

    exp_t q[$];

    int n_cmp = 0;
    int n_mis = 0;

    logic        m_led;
    logic [15:0] m_cmd;
    logic [7:0]  m_err;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Predict the event caused by a completed word
    task automatic push_word(input logic [31:0] w, input int at_cyc);
        logic ts, ce;
        exp_t e;
        ts = 1'b0;
        ce = 1'b0;
        if (w == 32'hBADC0FFE) begin
            if (test_busy) begin
                ce = 1'b1;
                m_err = sat_inc(m_err);
            end else begin
                ts = 1'b1;
                m_cmd = m_cmd + 16'd1;
            end
        end else if (w == 32'h001711ED) begin
            m_led = 1'b1;
            m_cmd = m_cmd + 16'd1;
        end else if (w == 32'h00FF11ED) begin
            m_led = 1'b0;
            m_cmd = m_cmd + 16'd1;
        end else begin
            ce = 1'b1;
            m_err = sat_inc(m_err);
        end
        e.at_cyc = at_cyc;
        e.snap   = {ts, ce, 1'b0, m_led, m_cmd, m_err};
        q.push_back(e);
    endtask

    task automatic push_timeout(input int at_cyc);
        exp_t e;
        m_err    = sat_inc(m_err);
        e.at_cyc = at_cyc;
        e.snap   = {1'b0, 1'b0, 1'b1, m_led, m_cmd, m_err};
        q.push_back(e);
    endtask

    // Caller sits at posedge+1; byte is valid for exactly one cycle
    task automatic send_byte(input logic [7:0] b);
        rxfifo_valid = 1'b1;
        rxfifo_data  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rxfifo_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] tmp;
        tmp = w;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) push_word(w, cyc + 1);
            send_byte(tmp[8*i +: 8]);
        end
    endtask

    // Monitor: any pulse or counter change is an event to be matched
    logic [15:0] prev_cmd = '0;
    logic [7:0]  prev_err = '0;
    always @(negedge clk) begin
        if (rst_n === 1'b1 &&
            (test_start || cmd_err || frame_timeout || cmd_cnt != prev_cmd || err_cnt != prev_err)) begin
            check_eq("sb_pending", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                check_eq("evt_cycle", 64'(cyc), 64'(e.at_cyc));
                check_eq("evt_value", 64'({test_start, cmd_err, frame_timeout, led0, cmd_cnt, err_cnt}),
                         64'(e.snap));
            end
        end
        prev_cmd <= cmd_cnt;
        prev_err <= err_cnt;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        rxfifo_valid = 1'b0;
        rxfifo_data  = 8'h00;
        rxfifo_empty = 1'b1;
        test_busy    = 1'b0;
        m_led        = 1'b0;
        m_cmd        = '0;
        m_err        = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_outputs",
                 64'({rxfifo_rd, test_start, cmd_err, frame_timeout, led0, cmd_cnt, err_cnt}), 64'd0);
        rst_n        = 1'b1;
        rxfifo_empty = 1'b0;
        idle(1);
        check_eq("rd_idle_nonempty", 64'(rxfifo_rd), 64'd1);

        // Test command, idle generator
        send_word(32'hBADC0FFE);
        rxfifo_valid = 1'b0;
        check_eq("rd_before_decode", 64'(rxfifo_rd), 64'd1);
        idle(1);
        check_eq("rd_after_decode", 64'(rxfifo_rd), 64'd0);
        idle(1);
        check_eq("rd_back_in_idle", 64'(rxfifo_rd), 64'd1);
        idle(2);

        // LED on then off
        send_word(32'h001711ED);
        idle(2);
        send_word(32'h00FF11ED);
        idle(3);

        // Test command while generator busy is rejected
        test_busy = 1'b1;
        send_word(32'hBADC0FFE);
        idle(2);
        test_busy = 1'b0;

        // Unknown word, then idempotent LED on
        send_word(32'h12345678);
        idle(2);
        send_word(32'h001711ED);
        idle(2);
        send_word(32'h001711ED);
        idle(2);

        // Back-to-back words with no gap: bytes land in DECODE each time
        send_word(32'h00FF11ED);
        send_word(32'h001711ED);
        send_word(32'hBADC0FFE);
        send_word(32'h00FF11ED);
        idle(3);

        // Partial word times out, next word decodes normally
        send_byte(8'hED);
        push_timeout(cyc + 1 + TO);
        send_byte(8'h11);
        idle(TO + 5);
        send_word(32'h001711ED);
        idle(3);

        // Byte arriving in the expiry cycle wins over the timeout
        send_byte(8'hED);
        idle(TO - 1);
        send_byte(8'h11);
        send_byte(8'hFF);
        push_word(32'h00FF11ED, cyc + 1);
        send_byte(8'h00);
        idle(3);

        // Reset mid-word discards the partial word silently
        send_byte(8'hFE);
        send_byte(8'h0F);
        rxfifo_valid = 1'b0;
        rst_n = 1'b0;
        m_led = 1'b0;
        m_cmd = '0;
        m_err = '0;
        @(posedge clk);
        #1;
        check_eq("midword_rst_outputs",
                 64'({test_start, cmd_err, frame_timeout, led0, cmd_cnt, err_cnt}), 64'd0);
        rst_n = 1'b1;
        idle(2);
        send_word(32'hBADC0FFE);
        idle(4);

        // Empty FIFO stops read requests
        rxfifo_empty = 1'b1;
        idle(2);
        check_eq("rd_when_empty", 64'(rxfifo_rd), 64'd0);
        check_eq("final_cmd_cnt", 64'(cmd_cnt), 64'(m_cmd));
        check_eq("final_err_cnt", 64'(err_cnt), 64'(m_err));
        check_eq("sb_drained", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
